// File: rtl/regbank_write_arbiter_if.sv
// Write-port bundle between the two writeback requesters, issue reservations
// and the register bank / scoreboard outputs of regbank_write_arbiter.
interface regbank_write_arbiter_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
);
    logic                 a_valid;
    logic                 a_ready;
    logic [ADDR_W-1:0]    a_reg;
    logic [DATA_W-1:0]    a_data;
    logic                 b_valid;
    logic                 b_ready;
    logic [ADDR_W-1:0]    b_reg;
    logic [DATA_W-1:0]    b_data;
    logic                 rsv_valid;
    logic [ADDR_W-1:0]    rsv_reg;
    logic                 RegWrite;
    logic [ADDR_W-1:0]    WriteRegister;
    logic [DATA_W-1:0]    WriteData;
    logic [2**ADDR_W-1:0] busy;

    modport master (
        output a_valid, a_reg, a_data, b_valid, b_reg, b_data, rsv_valid, rsv_reg,
        input  a_ready, b_ready, RegWrite, WriteRegister, WriteData, busy
    );

    modport slave (
        input  a_valid, a_reg, a_data, b_valid, b_reg, b_data, rsv_valid, rsv_reg,
        output a_ready, b_ready, RegWrite, WriteRegister, WriteData, busy
    );
endinterface

// File: rtl/regbank_write_arbiter.sv
// Round-robin arbiter sharing the register bank write port between the ALU (A)
// and load/multicycle (B) writeback paths, with a per-register busy scoreboard.
module regbank_write_arbiter #(
    parameter int DATA_W    = 32,
    parameter int ADDR_W    = 5,
    parameter int ZERO_DROP = 1
) (
    input logic                   clk,
    input logic                   rst,
    regbank_write_arbiter_if.slave bus
);
    localparam int NREG = 2**ADDR_W;

    typedef enum logic {GRANT_A, GRANT_B} grant_t;

    grant_t            lastGrant, lastGrantNext;
    logic              grantA, grantB, xfer, drop;
    logic [ADDR_W-1:0] xReg;
    logic [DATA_W-1:0] xData;
    logic [NREG-1:0]   busyNext;

    always_ff @(posedge clk) begin
        if (rst) begin
            lastGrant         <= GRANT_B;
            bus.RegWrite      <= 1'b0;
            bus.WriteRegister <= '0;
            bus.WriteData     <= '0;
            bus.busy          <= '0;
        end else begin
            lastGrant    <= lastGrantNext;
            bus.RegWrite <= xfer & ~drop;
            if (xfer && !drop) begin
                bus.WriteRegister <= xReg;
                bus.WriteData     <= xData;
            end
            bus.busy <= busyNext;
        end
    end

    always_comb begin
        grantA        = 1'b0;
        grantB        = 1'b0;
        lastGrantNext = lastGrant;
        if (!rst) begin
            grantA = bus.a_valid & (~bus.b_valid | (lastGrant == GRANT_B));
            grantB = bus.b_valid & (~bus.a_valid | (lastGrant == GRANT_A));
        end
        if (grantA)
            lastGrantNext = GRANT_A;
        else if (grantB)
            lastGrantNext = GRANT_B;

        xfer  = grantA | grantB;
        xReg  = grantA ? bus.a_reg  : bus.b_reg;
        xData = grantA ? bus.a_data : bus.b_data;
        drop  = (ZERO_DROP != 0) && (xReg == '0);

        bus.a_ready = grantA;
        bus.b_ready = grantB;

        // Clear before set so a same-cycle re-reservation of r stays outstanding.
        busyNext = bus.busy;
        if (xfer)
            busyNext[xReg] = 1'b0;
        if (bus.rsv_valid && bus.rsv_reg != '0)
            busyNext[bus.rsv_reg] = 1'b1;
        busyNext[0] = 1'b0;
    end
endmodule
